main_control_fsm: RTL and testbench

Multi-cycle main controller that sequences the shared RISC-V datapath (single ALU, unified instruction/data memory) one instruction at a time. It decodes the opcode and walks a Moore-style state machine driving mux selects, write enables and `ALUOp`. `ALUOp` and `Branch` feed the existing ALU decoder, which produces `ALUControl` and the branch PC-select. Memory accesses stall on a ready handshake.

---
 rtl/cpu_ctrl_pkg.sv | 70 +++++++
 rtl/main_control_fsm_if.sv | 55 +++++
 rtl/main_ctrl_outputs.sv | 101 ++++++++++
 rtl/main_control_fsm.sv | 125 ++++++++++++
 tb/tb_main_control_fsm.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the multi-cycle RISC-V datapath.
// Holds the controller state enum, the opcodes the controller decodes and the
// mux-select / ALUOp encodings that the ALU decoder also consumes.
// Optional feature macro: MCFSM_JALR_EN adds the JALR / JALWB states.
package cpu_ctrl_pkg;

    // Controller states; JALR support only exists when the macro is defined
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BEQ
`ifdef MCFSM_JALR_EN
        ,
        S_JALR,
        S_JALWB
`endif
    } state_t;

    // Opcodes handled by the controller
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUOp handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // Raw per-state control word, before memory-ready gating and reset forcing
    typedef struct packed {
        logic       pc_update;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_word_t;

endpackage

// File: rtl/main_control_fsm_if.sv
// Controller <-> datapath signal bundle.
// The master modport is the controller side (drives selects and enables),
// the slave modport is the datapath/memory side.
interface main_control_fsm_if;

    logic [6:0] op;
    logic       mem_ready;
    logic       PCUpdate;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       Branch;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ALUOp;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op,
        input  mem_ready,
        output PCUpdate,
        output IRWrite,
        output MemWrite,
        output RegWrite,
        output Branch,
        output AdrSrc,
        output ALUSrcA,
        output ALUSrcB,
        output ResultSrc,
        output ALUOp,
        output instr_done,
        output illegal
    );

    modport slave (
        output op,
        output mem_ready,
        input  PCUpdate,
        input  IRWrite,
        input  MemWrite,
        input  RegWrite,
        input  Branch,
        input  AdrSrc,
        input  ALUSrcA,
        input  ALUSrcB,
        input  ResultSrc,
        input  ALUOp,
        input  instr_done,
        input  illegal
    );

endinterface

// File: rtl/main_ctrl_outputs.sv
// Purely combinational state -> control word table for the main controller.
// Values here are the ungated Moore outputs; memory-ready gating of the fetch
// enables and reset forcing are applied by the top.
// Optional feature macro: MCFSM_JALR_EN adds the JALR / JALWB rows.
module main_ctrl_outputs
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t ctrl
);

    // Decode the current state into selects and enables; unlisted fields stay 0
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.ir_write   = 1'b1;
                ctrl.pc_update  = 1'b1;
            end
            S_DECODE: begin
                // Branch target OldPC + imm is parked in ALUOut here
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_write  = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_RD2;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_JAL: begin
                // ALU computes OldPC + 4 for the link while ALUOut (target) loads PC
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_RD2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
`ifdef MCFSM_JALR_EN
            S_JALR: begin
                // rs1 + imm goes straight from the ALU result into PC
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.pc_update  = 1'b1;
            end
            S_JALWB: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
                ctrl.reg_write  = 1'b1;
            end
`endif
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main controller for the shared RISC-V datapath.
// Holds the state register and next-state logic; the state -> control word
// table lives in main_ctrl_outputs. Memory accesses in FETCH, MEMREAD and
// MEMWRITE stall on mem_ready; every other state ignores it.
// Optional feature macro: MCFSM_JALR_EN adds jalr via the JALR / JALWB states;
// without it opcode 1100111 is reported as illegal.
module main_control_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    main_control_fsm_if.master  bus
);

    state_t     state_q;
    state_t     state_d;
    ctrl_word_t table_w;
    logic       illegal_c;
    logic       instr_done_c;
    logic       fetch_ok;

    main_ctrl_outputs u_outputs (
        .state (state_q),
        .ctrl  (table_w)
    );

    // FETCH enables only fire on the cycle the memory returns the instruction
    assign fetch_ok = (state_q != S_FETCH) | bus.mem_ready;

    // State register; reset parks the controller in FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection plus the illegal-opcode and end-of-instruction flags
    always_comb begin
        state_d   = state_q;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BEQ:            state_d = S_BEQ;
`ifdef MCFSM_JALR_EN
                    OP_JALR:           state_d = S_JALR;
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                state_d = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
`ifdef MCFSM_JALR_EN
            S_JALR:     state_d = S_JALWB;
            S_JALWB:    state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
        // Last cycle of an instruction is any cycle heading back to FETCH;
        // FETCH's own stall cycles are excluded by the state check
        instr_done_c = (state_d == S_FETCH) && (state_q != S_FETCH);
    end

    // Drive the datapath; reset forces every select and enable to 0
    always_comb begin
        bus.PCUpdate   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.Branch     = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ALUOp      = 2'b00;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        if (!rst) begin
            bus.PCUpdate   = table_w.pc_update & fetch_ok;
            bus.IRWrite    = table_w.ir_write & fetch_ok;
            bus.MemWrite   = table_w.mem_write;
            bus.RegWrite   = table_w.reg_write;
            bus.Branch     = table_w.branch;
            bus.AdrSrc     = table_w.adr_src;
            bus.ALUSrcA    = table_w.alu_src_a;
            bus.ALUSrcB    = table_w.alu_src_b;
            bus.ResultSrc  = table_w.result_src;
            bus.ALUOp      = table_w.alu_op;
            bus.instr_done = instr_done_c;
            bus.illegal    = illegal_c;
        end
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: directed instruction vectors with a per-opcode
// step-list model checked every cycle, plus literal per-test expectations.
// Build with or without MCFSM_JALR_EN; expectations follow the macro.
module tb_main_control_fsm;

    logic clk = 1'b0;
    logic rst;

    main_control_fsm_if bus ();

    main_control_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {PCUpdate, IRWrite, MemWrite, RegWrite, Branch, AdrSrc,
    //  ALUSrcA[1:0], ALUSrcB[1:0], ResultSrc[1:0], ALUOp[1:0], instr_done, illegal}
    logic [15:0] vec;
    assign vec = {bus.PCUpdate, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.Branch,
                  bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUOp,
                  bus.instr_done, bus.illegal};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Steps an instruction walks through
    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, ER = 6, EI = 7;
    localparam int AWB = 8, J = 9, B = 10, JR = 11, JWB = 12;

    // Required outputs of one step (instr_done / illegal added separately)
    function automatic logic [15:0] step_out(input int st, input logic rdy);
        logic [15:0] v;
        v = '0;
        case (st)
            F:   begin v[15] = rdy; v[14] = rdy; v[7:6] = 2'b10; v[5:4] = 2'b10; end
            D:   begin v[9:8] = 2'b01; v[7:6] = 2'b01; end
            MA:  begin v[9:8] = 2'b10; v[7:6] = 2'b01; end
            MR:  begin v[10] = 1'b1; end
            MWB: begin v[5:4] = 2'b01; v[12] = 1'b1; end
            MW:  begin v[10] = 1'b1; v[13] = 1'b1; end
            ER:  begin v[9:8] = 2'b10; v[3:2] = 2'b10; end
            EI:  begin v[9:8] = 2'b10; v[7:6] = 2'b01; v[3:2] = 2'b10; end
            AWB: begin v[12] = 1'b1; end
            J:   begin v[9:8] = 2'b01; v[7:6] = 2'b10; v[15] = 1'b1; end
            B:   begin v[9:8] = 2'b10; v[3:2] = 2'b01; v[11] = 1'b1; end
            JR:  begin v[9:8] = 2'b10; v[7:6] = 2'b01; v[5:4] = 2'b10; v[15] = 1'b1; end
            JWB: begin v[9:8] = 2'b01; v[7:6] = 2'b10; v[5:4] = 2'b10; v[12] = 1'b1; end
            default: v = '0;
        endcase
        return v;
    endfunction

    // Model: current instruction's step list and position in it
    int seq[6];
    int len = 2;
    int idx = 0;

    // Per-cycle compare of the DUT against the step-list model
    always @(negedge clk) begin
        logic [15:0] e;
        int st;
        logic stall;
        if (rst) begin
            check("reset_outputs", vec, 16'h0000);
            idx = 0; len = 2; seq[0] = F; seq[1] = D;
        end else begin
            if (idx == 1) begin
                seq[0] = F; seq[1] = D;
                case (bus.op)
                    7'b0000011: begin seq[2] = MA; seq[3] = MR; seq[4] = MWB; len = 5; end
                    7'b0100011: begin seq[2] = MA; seq[3] = MW; len = 4; end
                    7'b0110011: begin seq[2] = ER; seq[3] = AWB; len = 4; end
                    7'b0010011: begin seq[2] = EI; seq[3] = AWB; len = 4; end
                    7'b1101111: begin seq[2] = J;  seq[3] = AWB; len = 4; end
                    7'b1100011: begin seq[2] = B;  len = 3; end
`ifdef MCFSM_JALR_EN
                    7'b1100111: begin seq[2] = JR; seq[3] = JWB; len = 4; end
`endif
                    default:    len = 2;
                endcase
            end
            st    = seq[idx];
            stall = (st == F || st == MR || st == MW) && !bus.mem_ready;
            e     = step_out(st, bus.mem_ready);
            if (idx == len - 1 && !stall) e[1] = 1'b1;
            if (st == D && len == 2) e[0] = 1'b1;
            check("cycle_outputs", vec, e);
            if (!stall) begin
                idx++;
                if (idx == len) idx = 0;
            end
        end
    end

    // Per-instruction log of sampled outputs
    logic [15:0] log_q[32];
    int ncyc;

    // Run one instruction from FETCH until instr_done; stall bit c drops mem_ready in cycle c
    task automatic run_instr(input logic [6:0] opv, input logic [31:0] stall_mask);
        bit seen;
        seen = 1'b0;
        ncyc = 0;
        for (int c = 0; c < 32 && !seen; c++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            bus.op = opv;
            bus.mem_ready = !stall_mask[c];
            @(negedge clk);
            log_q[c] = vec;
            if (vec[1]) begin
                seen = 1'b1;
                ncyc = c + 1;
            end
        end
        if (!seen) check("instr_timeout", 16'h0000, 16'h0001);
    endtask

    function automatic int count_bit(input int b);
        int s;
        s = 0;
        for (int c = 0; c < ncyc; c++) s += int'(log_q[c][b]);
        return s;
    endfunction

    initial begin
        rst = 1'b1;
        bus.op = 7'b0110011;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 32; i++) log_q[i] = '0;

        // Reset held with an R-type opcode present
        repeat (2) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rst_all_zero", vec, 16'h0000);
        end

        // R-type right after reset: FETCH outputs on first cycle
        run_instr(7'b0110011, 32'h0);
        check("r_first_fetch", log_q[0], 16'hC0A0);
        check("r_cycles", 16'(ncyc), 16'd4);

        // lw: 5 cycles, writeback from Data in cycle 5, single done pulse
        run_instr(7'b0000011, 32'h0);
        check("lw_cycles", 16'(ncyc), 16'd5);
        check("lw_regwrite", {15'd0, log_q[4][12]}, 16'd1);
        check("lw_resultsrc", {14'd0, log_q[4][5:4]}, 16'd1);
        check("lw_done_count", 16'(count_bit(1)), 16'd1);

        // sw with 3 stall cycles in MEMWRITE
        run_instr(7'b0100011, 32'b111000);
        check("sw_cycles", 16'(ncyc), 16'd7);
        check("sw_memwrite_total", 16'(count_bit(13)), 16'd4);
        check("sw_memwrite_run", {12'd0, log_q[3][13], log_q[4][13], log_q[5][13], log_q[6][13]}, 16'hF);

        // beq: branch compare in cycle 3 only; fetch follows the sw
        run_instr(7'b1100011, 32'h0);
        check("after_sw_fetch", {15'd0, log_q[0][14]}, 16'd1);
        check("beq_cycles", 16'(ncyc), 16'd3);
        check("beq_branch_c3", {14'd0, log_q[2][11], log_q[2][3]}, 16'd2);
        check("beq_aluop_c3", {14'd0, log_q[2][3:2]}, 16'd1);
        check("beq_branch_total", 16'(count_bit(11)), 16'd1);

        // I-type with two fetch stall cycles
        run_instr(7'b0010011, 32'b11);
        check("i_cycles", 16'(ncyc), 16'd6);
        check("i_stall_irwrite", {15'd0, log_q[0][14]}, 16'd0);
        check("i_fetch_irwrite", {15'd0, log_q[2][14]}, 16'd1);

        // jal: PC update in cycle 3, link write in cycle 4
        run_instr(7'b1101111, 32'h0);
        check("jal_cycles", 16'(ncyc), 16'd4);
        check("jal_pcupdate", {15'd0, log_q[2][15]}, 16'd1);
        check("jal_regwrite", {15'd0, log_q[3][12]}, 16'd1);

        // Unsupported opcode
        run_instr(7'b1111111, 32'h0);
        check("ill_cycles", 16'(ncyc), 16'd2);
        check("ill_pulse", {14'd0, log_q[1][1:0]}, 16'd3);
        check("ill_no_writes", 16'(count_bit(12) + count_bit(13)), 16'd0);

        // jalr depends on the build option
        run_instr(7'b1100111, 32'h0);
`ifdef MCFSM_JALR_EN
        check("jalr_cycles", 16'(ncyc), 16'd4);
        check("jalr_pcupdate", {15'd0, log_q[2][15]}, 16'd1);
        check("jalr_regwrite", {15'd0, log_q[3][12]}, 16'd1);
`else
        check("jalr_cycles", 16'(ncyc), 16'd2);
        check("jalr_illegal", {15'd0, log_q[1][0]}, 16'd1);
`endif

        // lw with one MEMREAD stall
        run_instr(7'b0000011, 32'b1000);
        check("lw_stall_cycles", 16'(ncyc), 16'd6);

        // Abandon a lw in MEMADR with reset, then resume with an R-type
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            bus.op = 7'b0000011;
            bus.mem_ready = 1'b1;
            @(negedge clk);
            check("abandon_no_done", {15'd0, vec[1]}, 16'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_zero", vec, 16'h0000);
        run_instr(7'b0110011, 32'h0);
        check("midrst_fetch", log_q[0], 16'hC0A0);
        check("midrst_cycles", 16'(ncyc), 16'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
